// File: rtl/arm32_mc_core.sv
// Multi-cycle ARMv4 integer core: data processing, LDR/STR imm, B/BL.
// Ports: clk/reset, inst_req/pc/inst/inst_valid fetch, mem_req/writeM/addressM/outM/inM/mem_ack data, halted.
module arm32_mc_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int ADDR_W = 32,
  parameter bit NV_HALTS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              inst_req,
  output logic [ADDR_W-1:0] pc,
  input  logic [31:0]       inst,
  input  logic              inst_valid,
  output logic              mem_req,
  output logic              writeM,
  output logic [ADDR_W-1:0] addressM,
  output logic [31:0]       outM,
  input  logic [31:0]       inM,
  input  logic              mem_ack,
  output logic              halted
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  state_t      state;
  logic [31:0] ir;
  logic [31:0] rf [16];
  logic [3:0]  nzcv;

  logic [31:0] pcW, pc4, pc8;
  logic [31:0] rnVal, rmVal, rdVal;
  logic [31:0] op2, logRes, res, ax, bx;
  logic [31:0] lsAddr, brTgt;
  logic [32:0] sum;
  logic [4:0]  amt;
  logic [3:0]  opc, rdI;
  logic        shC, cin, isArith, writesRd, ovf;
  logic        isNv, pass, dpOk, lsOk, brOk;
  logic        doHalt, doDp, doMem, doBr;
  logic [3:0]  newFlags;

  function automatic logic [31:0] ror32(
    input logic [31:0] x,
    input logic [4:0]  r
  );
    return (x >> r) | (x << (6'd32 - {1'b0, r}));
  endfunction

  function automatic logic condOk(
    input logic [3:0] c,
    input logic [3:0] f
  );
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  always_comb begin
    pcW = 32'(pc);
    pc4 = pcW + 32'd4;
    pc8 = pcW + 32'd8;
    opc = ir[24:21];
    rdI = ir[15:12];
    amt = ir[11:7];
    // R15 as an operand reads as pc+8
    rnVal = (ir[19:16] == 4'hF) ? pc8 : rf[ir[19:16]];
    rmVal = (ir[3:0] == 4'hF) ? pc8 : rf[ir[3:0]];
    rdVal = (rdI == 4'hF) ? pc8 : rf[rdI];

    op2 = rmVal;
    shC = nzcv[1];
    if (ir[25]) begin
      op2 = ror32({24'b0, ir[7:0]}, {ir[11:8], 1'b0});
      shC = (ir[11:8] == 4'h0) ? nzcv[1] : op2[31];
    end else begin
      // imm5=0 selects LSR#32, ASR#32 and RRX
      case (ir[6:5])
        2'b00: begin
          if (amt != 5'd0) begin
            op2 = rmVal << amt;
            shC = rmVal[5'd0 - amt];
          end
        end
        2'b01: begin
          op2 = (amt == 5'd0) ? 32'd0 : rmVal >> amt;
          shC = (amt == 5'd0) ? rmVal[31] : rmVal[amt - 5'd1];
        end
        2'b10: begin
          op2 = (amt == 5'd0) ? {32{rmVal[31]}}
                              : 32'($signed(rmVal) >>> amt);
          shC = (amt == 5'd0) ? rmVal[31] : rmVal[amt - 5'd1];
        end
        default: begin
          op2 = (amt == 5'd0) ? {nzcv[1], rmVal[31:1]}
                              : ror32(rmVal, amt);
          shC = (amt == 5'd0) ? rmVal[0] : rmVal[amt - 5'd1];
        end
      endcase
    end

    ax  = rnVal;
    bx  = op2;
    cin = 1'b0;
    case (opc)
      4'h2, 4'hA: begin bx = ~op2; cin = 1'b1; end
      4'h3: begin ax = op2; bx = ~rnVal; cin = 1'b1; end
      4'h5: cin = nzcv[1];
      4'h6: begin bx = ~op2; cin = nzcv[1]; end
      4'h7: begin ax = op2; bx = ~rnVal; cin = nzcv[1]; end
      default: ;
    endcase
    sum = {1'b0, ax} + {1'b0, bx} + {32'd0, cin};
    ovf = (ax[31] == bx[31]) && (sum[31] != ax[31]);

    case (opc)
      4'h0, 4'h8: logRes = rnVal & op2;
      4'h1, 4'h9: logRes = rnVal ^ op2;
      4'hC:       logRes = rnVal | op2;
      4'hE:       logRes = rnVal & ~op2;
      4'hF:       logRes = ~op2;
      default:    logRes = op2;
    endcase

    isArith  = (opc >= 4'h2 && opc <= 4'h7) || opc == 4'hA || opc == 4'hB;
    writesRd = opc[3:2] != 2'b10;
    res      = isArith ? sum[31:0] : logRes;
    newFlags = {res[31], res == 32'd0,
                isArith ? sum[32] : shC,
                isArith ? ovf : nzcv[0]};

    lsAddr = ir[23] ? rnVal + {20'd0, ir[11:0]}
                    : rnVal - {20'd0, ir[11:0]};
    brTgt  = pc8 + {{6{ir[23]}}, ir[23:0], 2'b00};

    isNv   = ir[31:28] == 4'hF;
    pass   = !isNv && condOk(ir[31:28], nzcv);
    dpOk   = ir[27:26] == 2'b00 && (ir[25] || !ir[4]);
    lsOk   = ir[27:26] == 2'b01 && !ir[25] && ir[24] && !ir[22] && !ir[21];
    brOk   = ir[27:25] == 3'b101;
    doHalt = isNv && NV_HALTS;
    doDp   = pass && dpOk;
    doMem  = pass && lsOk;
    doBr   = pass && brOk;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC[ADDR_W-1:0];
      ir       <= 32'd0;
      nzcv     <= 4'd0;
      for (int i = 0; i < 16; i++) rf[i] <= 32'd0;
      inst_req <= 1'b1;
      mem_req  <= 1'b0;
      writeM   <= 1'b0;
      addressM <= '0;
      outM     <= 32'd0;
      halted   <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (inst_valid) begin
            ir       <= inst;
            state    <= EXEC;
            inst_req <= 1'b0;
          end
        end
        EXEC: begin
          state    <= FETCH;
          inst_req <= 1'b1;
          unique case (1'b1)
            doHalt: begin
              state    <= HALT;
              inst_req <= 1'b0;
              halted   <= 1'b1;
            end
            doDp: begin
              if (ir[20]) nzcv <= newFlags;
              if (writesRd && rdI == 4'hF)
                pc <= {res[ADDR_W-1:2], 2'b00};
              else begin
                pc <= pc4[ADDR_W-1:0];
                if (writesRd) rf[rdI] <= res;
              end
            end
            doMem: begin
              state    <= MEM;
              inst_req <= 1'b0;
              mem_req  <= 1'b1;
              writeM   <= !ir[20];
              addressM <= lsAddr[ADDR_W-1:0];
              outM     <= rdVal;
            end
            doBr: begin
              pc <= brTgt[ADDR_W-1:0];
              if (ir[24]) rf[14] <= pc4;
            end
            default: pc <= pc4[ADDR_W-1:0];
          endcase
        end
        MEM: begin
          if (mem_ack) begin
            state    <= FETCH;
            inst_req <= 1'b1;
            mem_req  <= 1'b0;
            writeM   <= 1'b0;
            pc       <= pc4[ADDR_W-1:0];
            if (!writeM) begin
              if (rdI == 4'hF) pc <= {inM[ADDR_W-1:2], 2'b00};
              else rf[rdI] <= inM;
            end
          end
        end
        HALT: ;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_arm32_mc_core.sv
// Directed bench for arm32_mc_core: ROM-fed fetch, delayed-ack data RAM.
// Checks pc, bus outputs, registers and flags against hand-computed values.
module tb_arm32_mc_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req, inst_valid;
  logic [31:0] pc, inst;
  logic        mem_req, writeM, mem_ack, halted;
  logic [31:0] addressM, outM, inM;

  logic [31:0] rom [64];
  logic [31:0] dmem [64];
  int          ackDelay = 1;
  int          waitCnt = 0;
  int          reqCount = 0;
  logic        preEn = 1'b0;
  logic [5:0]  preIdx = 6'd0;
  logic [31:0] preVal = 32'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arm32_mc_core #(
    .RESET_PC(32'h0),
    .ADDR_W(32),
    .NV_HALTS(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .inst_req(inst_req),
    .pc(pc),
    .inst(inst),
    .inst_valid(inst_valid),
    .mem_req(mem_req),
    .writeM(writeM),
    .addressM(addressM),
    .outM(outM),
    .inM(inM),
    .mem_ack(mem_ack),
    .halted(halted)
  );

  assign inst       = rom[pc[7:2]];
  assign inst_valid = inst_req;
  assign inM        = dmem[addressM[7:2]];
  assign mem_ack    = mem_req && (waitCnt == ackDelay - 1);

  always @(posedge clk) begin
    if (!mem_req || mem_ack) waitCnt <= 0;
    else waitCnt <= waitCnt + 1;
    if (mem_req) reqCount <= reqCount + 1;
    if (mem_req && mem_ack && writeM) dmem[addressM[7:2]] <= outM;
    else if (preEn) dmem[preIdx] <= preVal;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic fillNop;
    for (int i = 0; i < 64; i++) rom[i] = 32'hE1A00000;
  endtask

  task automatic waitReq(input string tag);
    int n = 0;
    while (!mem_req && n < 50) begin
      cyc(1);
      n++;
    end
    chk(tag, 32'(mem_req), 32'd1);
  endtask

  task automatic reqLen(output int n);
    n = 0;
    while (mem_req && n < 50) begin
      n++;
      cyc(1);
    end
  endtask

  int base, len;

  initial begin
    // basic sequence, zero-wait
    fillNop();
    rom[0] = 32'hE3A00005;
    rom[1] = 32'hE2801003;
    doReset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst_req", 32'(inst_req), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_writeM", 32'(writeM), 32'd0);
    chk("rst_addressM", addressM, 32'h0);
    chk("rst_outM", outM, 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    base = reqCount;
    cyc(4);
    chk("t1_pc", pc, 32'h8);
    chk("t1_r0", dut.rf[0], 32'd5);
    chk("t1_r1", dut.rf[1], 32'd8);
    chk("t1_no_mem", 32'(reqCount - base), 32'd0);

    // flags and conditional execution
    fillNop();
    rom[0] = 32'hE3A00000;
    rom[1] = 32'hE2502001;
    rom[2] = 32'h03A03009;
    rom[3] = 32'hE3E07102;
    rom[4] = 32'hE2978001;
    rom[5] = 32'h63A09001;
    rom[6] = 32'hE1580008;
    rom[7] = 32'h03A0A003;
    doReset();
    cyc(4);
    chk("subs_r2", dut.rf[2], 32'hFFFF_FFFF);
    chk("subs_nzcv", 32'(dut.nzcv), 32'h8);
    cyc(2);
    chk("moveq_pc", pc, 32'hC);
    chk("moveq_r3", dut.rf[3], 32'd0);
    cyc(4);
    chk("mvn_r7", dut.rf[7], 32'h7FFF_FFFF);
    chk("adds_r8", dut.rf[8], 32'h8000_0000);
    chk("adds_nzcv", 32'(dut.nzcv), 32'h9);
    cyc(2);
    chk("movvs_r9", dut.rf[9], 32'd1);
    cyc(4);
    chk("cmp_nzcv", 32'(dut.nzcv), 32'h6);
    chk("moveq_r10", dut.rf[10], 32'd3);

    // shifts, store/load with 3-cycle ack
    fillNop();
    rom[0] = 32'hE3A00C01;
    rom[1] = 32'hE3A01008;
    rom[2] = 32'hE0815101;
    rom[3] = 32'hE2616000;
    rom[4] = 32'hE1B0B026;
    rom[5] = 32'hE5801004;
    rom[6] = 32'hE5904004;
    ackDelay = 3;
    doReset();
    waitReq("str_timeout");
    chk("str_addr", addressM, 32'h104);
    chk("str_writeM", 32'(writeM), 32'd1);
    chk("str_outM", outM, 32'd8);
    reqLen(len);
    chk("str_req_cycles", 32'(len), 32'd3);
    chk("str_mem", dmem[1], 32'd8);
    waitReq("ldr_timeout");
    chk("ldr_writeM", 32'(writeM), 32'd0);
    chk("ldr_addr", addressM, 32'h104);
    reqLen(len);
    chk("ldr_req_cycles", 32'(len), 32'd3);
    chk("ldr_r4", dut.rf[4], 32'd8);
    chk("ldr_pc", pc, 32'h1C);
    chk("lsl_r5", dut.rf[5], 32'd40);
    chk("rsb_r6", dut.rf[6], 32'hFFFF_FFF8);
    chk("lsr32_r11", dut.rf[11], 32'd0);
    chk("lsr32_nzcv", 32'(dut.nzcv), 32'h6);

    // branch and link, return
    fillNop();
    rom[8]  = 32'hEB000004;
    rom[14] = 32'hE1A0F00E;
    ackDelay = 1;
    doReset();
    cyc(16);
    chk("pre_bl_pc", pc, 32'h20);
    cyc(2);
    chk("bl_pc", pc, 32'h38);
    chk("bl_r14", dut.rf[14], 32'h24);
    cyc(2);
    chk("ret_pc", pc, 32'h24);

    // reset while a load waits for ack
    fillNop();
    rom[0] = 32'hE3A00C01;
    rom[1] = 32'hE5904008;
    preIdx = 6'd2;
    preVal = 32'h55;
    preEn = 1'b1;
    ackDelay = 20;
    doReset();
    preEn = 1'b0;
    waitReq("abort_timeout");
    cyc(2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_pc", pc, 32'h0);
    chk("abort_r4", dut.rf[4], 32'd0);
    ackDelay = 1;
    cyc(10);
    chk("rerun_r4", dut.rf[4], 32'h55);

    // NV halts
    fillNop();
    rom[0] = 32'hF0000000;
    doReset();
    cyc(2);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_inst_req", 32'(inst_req), 32'd0);
    cyc(5);
    chk("halt_stays", 32'(halted), 32'd1);
    chk("halt_pc", pc, 32'h0);
    chk("halt_no_fetch", 32'(inst_req), 32'd0);
    doReset();
    chk("unhalt", 32'(halted), 32'd0);
    chk("unhalt_inst_req", 32'(inst_req), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
